bcd_time_keeper: RTL

Downstream consumer of the UART command parser. Holds a 24-hour BCD time-of-day (HH:MM:SS) and advances it once per second from a clk prescaler.
- Loaded from the parser's six decoded digits on its write-ready strobe.
- Started, stopped and cleared by decoded command pulses.
- Reports invalid loads on a one-cycle error pulse that feeds the parser's error input.

---
 rtl/bcd_time_keeper_if.sv | 35 +++
 rtl/bcd_time_keeper.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bcd_time_keeper_if.sv
// Command/status bundle between the UART command parser (master) and the BCD time keeper (slave).
// The alarm signals exist only when ALARM_EN is defined.
interface bcd_time_keeper_if;
    logic       load;
    logic [3:0] ld_d1, ld_d2, ld_d3, ld_d4, ld_d5, ld_d6;
    logic       start;
    logic       stop;
    logic       clr;
    logic       run;
    logic [3:0] t_d1, t_d2, t_d3, t_d4, t_d5, t_d6;
    logic       sec_tick;
    logic       load_err;
`ifdef ALARM_EN
    logic       alarm_ld;
    logic       alarm_hit;
`endif

    modport master (
        output load, ld_d1, ld_d2, ld_d3, ld_d4, ld_d5, ld_d6, start, stop, clr,
`ifdef ALARM_EN
        output alarm_ld,
        input  alarm_hit,
`endif
        input  run, t_d1, t_d2, t_d3, t_d4, t_d5, t_d6, sec_tick, load_err
    );

    modport slave (
        input  load, ld_d1, ld_d2, ld_d3, ld_d4, ld_d5, ld_d6, start, stop, clr,
`ifdef ALARM_EN
        input  alarm_ld,
        output alarm_hit,
`endif
        output run, t_d1, t_d2, t_d3, t_d4, t_d5, t_d6, sec_tick, load_err
    );
endinterface

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD HH:MM:SS keeper advanced once per TICK_DIV clocks while running.
// Optional alarm register/comparator enabled by defining ALARM_EN.
module bcd_time_keeper #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic                clk,
    input  logic                rst,
    bcd_time_keeper_if.slave    bus_io
);

    typedef enum logic [0:0] {StStopped, StRunning} state_e;

    // Time packed as {h1, h0, m1, m0, s1, s0}, one BCD digit per nibble.
    function automatic logic digits_valid(input logic [23:0] t);
        return (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) &&
               ((t[23:20] != 4'd2) || (t[19:16] <= 4'd3)) &&
               (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        if (h1 == 4'd2 && h0 == 4'd3) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (h0 == 4'd9) begin
                            h0 = 4'd0;
                            h1 = h1 + 4'd1;
                        end else begin
                            h0 = h0 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       time_q, time_d;
    logic              sec_tick_q, sec_tick_d;
    logic              load_err_q, load_err_d;
    logic [23:0]       ld_time;
    logic              ld_ok;
    logic              wrap;
`ifdef ALARM_EN
    logic [23:0]       alarm_q, alarm_d;
    logic              alarm_hit_q, alarm_hit_d;
`endif

    always_comb begin
        ld_time    = {bus_io.ld_d1, bus_io.ld_d2, bus_io.ld_d3,
                      bus_io.ld_d4, bus_io.ld_d5, bus_io.ld_d6};
        ld_ok      = digits_valid(ld_time);
        wrap       = (state_q == StRunning) && (cnt_q == CNT_W'(TICK_DIV - 1));

        state_d    = state_q;
        cnt_d      = cnt_q;
        time_d     = time_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;

        unique case (state_q)
            StStopped: if (bus_io.start && !bus_io.stop && !bus_io.clr) state_d = StRunning;
            StRunning: if (bus_io.stop || bus_io.clr) state_d = StStopped;
            default:   state_d = StStopped;
        endcase

        // The prescaler holds while stopped so a stop/start pair resumes mid-second.
        if (state_q == StRunning) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end

        if (bus_io.clr) begin
            time_d = '0;
            cnt_d  = '0;
        end else if (bus_io.load && ld_ok) begin
            time_d = ld_time;
            cnt_d  = '0;
        end else begin
            load_err_d = bus_io.load;
            if (wrap) begin
                time_d     = bcd_inc(time_q);
                sec_tick_d = 1'b1;
            end
        end

`ifdef ALARM_EN
        alarm_d = alarm_q;
        if (bus_io.alarm_ld) begin
            if (ld_ok) alarm_d = ld_time;
            else       load_err_d = 1'b1;
        end
        // sec_tick_q marks the cycle right after a tick, so only ticks (not loads) hit.
        alarm_hit_d = sec_tick_q && (time_q == alarm_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StStopped;
            cnt_q      <= '0;
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef ALARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q     <= '0;
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign bus_io.alarm_hit = alarm_hit_q;
`endif

    assign bus_io.run      = (state_q == StRunning);
    assign bus_io.sec_tick = sec_tick_q;
    assign bus_io.load_err = load_err_q;
    assign {bus_io.t_d1, bus_io.t_d2, bus_io.t_d3,
            bus_io.t_d4, bus_io.t_d5, bus_io.t_d6} = time_q;

endmodule
